code84n_deserializer: RTL
=========================

# code84n_deserializer

Multi-digit decoder for the 8,4,-2,-1 weighted decimal code (0→0000, 1→0111, 2→0110, 3→0101, 4→0100, 5→1011, 6→1010, 7→1001, 8→1000, 9→1111). It accepts one 4-bit coded digit per handshake, most significant digit first, and validates each code. It accumulates the frame into an unsigned binary value and presents the result with a valid/ready handshake. It is the receive-side counterpart of the 8,4,-2,-1 BCD encoder in the same W2 exercise set.

## Interface
- NDIGITS, 4: maximum digits per frame (1..8).
- OUT_W, 14: result width; must satisfy 2^OUT_W ≥ 10^NDIGITS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  in_code/in_last valid.
- in_ready  out  1  block can accept a digit.
- in_code  in  4  8,4,-2,-1 coded digit.
- in_last  in  1  final digit of frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_value  out  OUT_W  binary value of frame.
- out_ndig  out  4  digits accepted in frame (1..NDIGITS).
- out_err  out  2  [0] invalid code seen; [1] length overrun.

## Operation
- Two states: ACC (collecting) and DONE (result held).
- Reset: state=ACC, acc=0, count=0, err=00, out_valid=0, out_value=0, out_ndig=0, out_err=00. in_ready=1 from the first edge after release.
- ACC: in_ready=1, out_valid=0. Digit accepted when in_valid&in_ready at a clock edge.
  - Decode: use the ten legal codes above. The six illegal codes (0001, 0010, 0011, 1100, 1101, 1110) decode as digit 0 and set sticky err[0].
  - acc ← acc*10 + digit, truncated to OUT_W bits; no wrap for legal parameters. count ← count+1.
  - Frame ends when the accepted digit has in_last=1, or when count reaches NDIGITS. If the frame ends on count with in_last=0, set err[1]. The next digit starts a new frame.
  - At frame end, register out_value, out_ndig and out_err from the updated values, then go to DONE.
- DONE: out_valid=1, in_ready=0. Outputs are stable until out_valid&out_ready at an edge. That edge returns to ACC and clears acc, count and err; out_valid drops.
- in_last on an illegal code still ends the frame, with err[0] set.
- Reset mid-frame or in DONE discards everything and returns to the reset values immediately, asynchronously.

## Timing
- in_ready is a function of state only (no combinational path from out_ready). out_valid is registered.
- Latency: out_valid rises on the edge that accepts the terminating digit and is visible in the following cycle.
- Minimum frame period is N+1 cycles for N digits with out_ready held at 1: N accept cycles plus one DONE cycle.
- in_ready is 0 during the DONE cycle. No digit is accepted in the cycle the result is consumed; acceptance resumes the next cycle.
- Back-to-back digits are accepted at one per cycle in ACC with no bubbles.

## Test plan
- Reset, then send codes 1001,0100,1111,1011 with in_last on the fourth → out_value=7495, out_ndig=4, out_err=00, out_valid one cycle after the last accept.
- Send single 0000 with in_last → out_value=0, out_ndig=1, out_err=00. Then send 1111 with in_last → out_value=9.
- Send 0000 then 0001 with in_last → out_value=0, out_ndig=2, out_err=01. Next frame 0110 with last → 2, err=00 (sticky cleared).
- Send five 0111 digits with no in_last → first frame: out_value=1111, out_ndig=4, out_err=10. Fifth digit starts new frame, accepted only after the first result is consumed.
- With a result pending, hold out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs unchanged. Assert out_ready → in_ready=1 the next cycle.
- Assert rst_n=0 asynchronously after two digits of a frame → all outputs return to reset values immediately. A new frame 1000 with last → value 8, no residue from the aborted frame.

Source files
------------

// File: rtl/code84n_deserializer.sv
// code84n_deserializer: collects MSD-first 8,4,-2,-1 coded digits into a binary value
// and presents each completed frame over a valid/ready handshake.
module code84n_deserializer #(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [3:0]       out_ndig,
  output logic [1:0]       out_err
);
  typedef enum logic {ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d, val_q, val_d, acc_upd;
  logic [3:0]       cnt_q, cnt_d, ndig_q, ndig_d, cnt_inc, digit;
  logic [1:0]       err_q, err_d, oerr_q, oerr_d, err_upd;
  logic             rdy_q, ovalid_q, ovalid_d, bad, frame_end;
  always_comb begin
    digit = 4'd0;
    bad   = 1'b0;
    case (in_code)
      4'b0000: digit = 4'd0;
      4'b0111: digit = 4'd1;
      4'b0110: digit = 4'd2;
      4'b0101: digit = 4'd3;
      4'b0100: digit = 4'd4;
      4'b1011: digit = 4'd5;
      4'b1010: digit = 4'd6;
      4'b1001: digit = 4'd7;
      4'b1000: digit = 4'd8;
      4'b1111: digit = 4'd9;
      default: bad = 1'b1;
    endcase
  end
  assign cnt_inc   = cnt_q + 4'd1;
  assign acc_upd   = acc_q * OUT_W'(10) + OUT_W'(digit);
  assign frame_end = in_last | (cnt_inc == 4'(NDIGITS));
  assign err_upd   = err_q | {~in_last & (cnt_inc == 4'(NDIGITS)), bad};
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    val_d    = val_q;
    ndig_d   = ndig_q;
    oerr_d   = oerr_q;
    ovalid_d = ovalid_q;
    if (state_q == ACC) begin
      if (in_valid && rdy_q) begin
        acc_d = acc_upd;
        cnt_d = cnt_inc;
        err_d = err_upd;
        if (frame_end) begin
          val_d    = acc_upd;
          ndig_d   = cnt_inc;
          oerr_d   = err_upd;
          ovalid_d = 1'b1;
          state_d  = DONE;
        end
      end
    end else if (out_ready) begin
      state_d  = ACC;
      ovalid_d = 1'b0;
      acc_d    = '0;
      cnt_d    = '0;
      err_d    = '0;
    end
  end
  // in_ready is registered from the next state, so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      val_q    <= '0;
      ndig_q   <= '0;
      oerr_q   <= '0;
      ovalid_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      val_q    <= val_d;
      ndig_q   <= ndig_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
      rdy_q    <= (state_d == ACC);
    end
  end
  assign in_ready  = rdy_q;
  assign out_valid = ovalid_q;
  assign out_value = val_q;
  assign out_ndig  = ndig_q;
  assign out_err   = oerr_q;
endmodule
